// File: rtl/led_matrix_bcm_driver.sv
// HUB75 scan driver with binary-code-modulated colour: shifts one bit-plane per pass,
// latches it, then lights the row for an on-time weighted by the plane's binary significance.
module led_matrix_bcm_driver #(
    parameter int NUM_ROWS       = 32,
    parameter int NUM_COLS       = 64,
    parameter int COLOUR_DEPTH   = 4,
    parameter int CLK_DIV        = 50,
    parameter int BASE_ON_CYCLES = 64,
    parameter int ROW_W          = $clog2(NUM_ROWS / 2),
    parameter int COL_W          = $clog2(NUM_COLS)
) (
    input  logic                      clk_in,
    input  logic                      n_reset_in,
    input  logic                      enable_in,
    output logic                      pix_rd_en_out,
    output logic [ROW_W-1:0]          pix_row_out,
    output logic [COL_W-1:0]          pix_col_out,
    input  logic [3*COLOUR_DEPTH-1:0] pix_top_in,
    input  logic [3*COLOUR_DEPTH-1:0] pix_bot_in,
    output logic [2:0]                rgb_top_out,
    output logic [2:0]                rgb_bot_out,
    output logic                      bit_clk_out,
    output logic                      latch_enable_out,
    output logic                      output_enable_out,
    output logic [ROW_W-1:0]          addr_out,
    output logic                      busy_out,
    output logic                      frame_done_out
);

    localparam int PLANE_W   = (COLOUR_DEPTH > 1) ? $clog2(COLOUR_DEPTH) : 1;
    localparam int MAX_ON    = BASE_ON_CYCLES << (COLOUR_DEPTH - 1);
    localparam int TIMER_MAX = (MAX_ON > CLK_DIV) ? MAX_ON : CLK_DIV;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0] DIV_LAST   = TIMER_W'(CLK_DIV - 1);
    localparam logic [TIMER_W-1:0] BASE_T     = TIMER_W'(BASE_ON_CYCLES);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(NUM_ROWS / 2 - 1);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(NUM_COLS - 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(COLOUR_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CLK_LO,
        CLK_HI,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    state_t             state_reg, state_next;
    logic [ROW_W-1:0]   row_reg, row_next;
    logic [COL_W-1:0]   col_reg, col_next;
    logic [PLANE_W-1:0] plane_reg, plane_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic [2:0]         rgb_top_reg, rgb_bot_reg;
    logic [ROW_W-1:0]   addr_reg;

    logic [TIMER_W-1:0] on_last;
    logic               div_done;
    logic               on_done;
    logic               frame_end;
    logic [2:0]         top_sel, bot_sel;

    assign on_last   = (BASE_T << plane_reg) - TIMER_W'(1);
    assign div_done  = (timer_reg == DIV_LAST);
    assign on_done   = (state_reg == DISPLAY) && (timer_reg == on_last);
    assign frame_end = on_done && (plane_reg == PLANE_LAST) && (row_reg == ROW_LAST);

    // Pick bit [plane] out of each colour channel; channel 2 is R, 0 is B.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [COLOUR_DEPTH-1:0] top_ch;
            logic [COLOUR_DEPTH-1:0] bot_ch;
            assign top_ch      = pix_top_in[gi*COLOUR_DEPTH +: COLOUR_DEPTH];
            assign bot_ch      = pix_bot_in[gi*COLOUR_DEPTH +: COLOUR_DEPTH];
            assign top_sel[gi] = top_ch[plane_reg];
            assign bot_sel[gi] = bot_ch[plane_reg];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        plane_next = plane_reg;
        timer_next = '0;
        case (state_reg)
            IDLE: begin
                if (enable_in) begin
                    state_next = FETCH;
                    row_next   = '0;
                    col_next   = '0;
                    plane_next = '0;
                end
            end
            FETCH: state_next = CLK_LO;
            CLK_LO: begin
                if (div_done) state_next = CLK_HI;
                else          timer_next = timer_reg + TIMER_W'(1);
            end
            CLK_HI: begin
                if (!div_done) begin
                    timer_next = timer_reg + TIMER_W'(1);
                end else if (col_reg != COL_LAST) begin
                    col_next   = col_reg + COL_W'(1);
                    state_next = FETCH;
                end else begin
                    col_next   = '0;
                    state_next = BLANK;
                end
            end
            BLANK: state_next = LATCH;
            LATCH: state_next = DISPLAY;
            DISPLAY: begin
                if (!on_done) begin
                    timer_next = timer_reg + TIMER_W'(1);
                end else if (plane_reg != PLANE_LAST) begin
                    plane_next = plane_reg + PLANE_W'(1);
                    state_next = FETCH;
                end else if (row_reg != ROW_LAST) begin
                    plane_next = '0;
                    row_next   = row_reg + ROW_W'(1);
                    state_next = FETCH;
                end else begin
                    // enable_in is only consulted here, so a frame always runs to completion
                    plane_next = '0;
                    row_next   = '0;
                    state_next = enable_in ? FETCH : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!n_reset_in) begin
            state_reg   <= IDLE;
            row_reg     <= '0;
            col_reg     <= '0;
            plane_reg   <= '0;
            timer_reg   <= '0;
            rgb_top_reg <= '0;
            rgb_bot_reg <= '0;
            addr_reg    <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            plane_reg <= plane_next;
            timer_reg <= timer_next;
            // Read data arrives during the first low-phase cycle; capture it before the rising edge.
            if (state_reg == CLK_LO && timer_reg == '0) begin
                rgb_top_reg <= top_sel;
                rgb_bot_reg <= bot_sel;
            end else if (state_next == BLANK) begin
                rgb_top_reg <= '0;
                rgb_bot_reg <= '0;
            end
            // Row select moves only while latching; parked at 0 once the driver goes idle.
            if (state_next == LATCH)     addr_reg <= row_reg;
            else if (state_next == IDLE) addr_reg <= '0;
        end
    end

    assign pix_rd_en_out     = (state_reg == FETCH);
    assign pix_row_out       = row_reg;
    assign pix_col_out       = col_reg;
    assign rgb_top_out       = rgb_top_reg;
    assign rgb_bot_out       = rgb_bot_reg;
    assign bit_clk_out       = (state_reg == CLK_HI);
    assign latch_enable_out  = (state_reg == LATCH);
    assign output_enable_out = (state_reg == DISPLAY);
    assign addr_out          = addr_reg;
    assign busy_out          = (state_reg != IDLE);
    assign frame_done_out    = frame_end;

endmodule

// File: tb/tb_led_matrix_bcm_driver.sv
// Bench for led_matrix_bcm_driver: a small 4x4, 2-bit instance checked plane by plane against
// a frame-buffer model, plus a default-size instance checked for bit-clock and on-time weights.
module tb_led_matrix_bcm_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Small configuration: 2 scan rows, 4 columns, 2 bit-planes, CLK_DIV=1, BASE_ON=2
    logic       n_reset_s, enable_s;
    logic       rd_en_s;
    logic [0:0] row_s;
    logic [1:0] col_s;
    logic [5:0] pix_top_s, pix_bot_s;
    logic [2:0] rgb_top_s, rgb_bot_s;
    logic       bclk_s, latch_s, oe_s, busy_s, done_s;
    logic [0:0] addr_s;

    led_matrix_bcm_driver #(
        .NUM_ROWS(4), .NUM_COLS(4), .COLOUR_DEPTH(2), .CLK_DIV(1), .BASE_ON_CYCLES(2)
    ) dut_s (
        .clk_in(clk), .n_reset_in(n_reset_s), .enable_in(enable_s),
        .pix_rd_en_out(rd_en_s), .pix_row_out(row_s), .pix_col_out(col_s),
        .pix_top_in(pix_top_s), .pix_bot_in(pix_bot_s),
        .rgb_top_out(rgb_top_s), .rgb_bot_out(rgb_bot_s),
        .bit_clk_out(bclk_s), .latch_enable_out(latch_s), .output_enable_out(oe_s),
        .addr_out(addr_s), .busy_out(busy_s), .frame_done_out(done_s)
    );

    // Default configuration
    logic        n_reset_d, enable_d;
    logic        rd_en_d;
    logic [3:0]  row_d;
    logic [5:0]  col_d;
    logic [11:0] pix_top_d, pix_bot_d;
    logic [2:0]  rgb_top_d, rgb_bot_d;
    logic        bclk_d, latch_d, oe_d, busy_d, done_d;
    logic [3:0]  addr_d;

    led_matrix_bcm_driver dut_d (
        .clk_in(clk), .n_reset_in(n_reset_d), .enable_in(enable_d),
        .pix_rd_en_out(rd_en_d), .pix_row_out(row_d), .pix_col_out(col_d),
        .pix_top_in(pix_top_d), .pix_bot_in(pix_bot_d),
        .rgb_top_out(rgb_top_d), .rgb_bot_out(rgb_bot_d),
        .bit_clk_out(bclk_d), .latch_enable_out(latch_d), .output_enable_out(oe_d),
        .addr_out(addr_d), .busy_out(busy_d), .frame_done_out(done_d)
    );

    // Frame buffer model: data valid exactly one cycle after the read strobe, noise otherwise.
    logic [5:0] fb_top [2][4];
    logic [5:0] fb_bot [2][4];

    always @(posedge clk) begin
        if (rd_en_s) begin
            pix_top_s <= fb_top[row_s][col_s];
            pix_bot_s <= fb_bot[row_s][col_s];
        end else begin
            pix_top_s <= 6'($urandom);
            pix_bot_s <= 6'($urandom);
        end
        pix_top_d <= 12'($urandom);
        pix_bot_d <= 12'($urandom);
    end

    int         checks   = 0;
    int         failures = 0;
    logic [0:0] last_addr = 1'b0;
    logic [2:0] last_rgb_top;
    int         done_cyc;

    // {R[p],G[p],B[p]} for a 2-bit-per-channel pixel {R[5:4],G[3:2],B[1:0]}
    function automatic logic [2:0] plane_bits(input logic [5:0] v, input int p);
        logic [5:0] s;
        s = v >> p;
        return {s[4], s[2], s[0]};
    endfunction

    task automatic randomize_fb();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) begin
                fb_top[r][c] = 6'($urandom);
                fb_bot[r][c] = 6'($urandom);
            end
    endtask

    // Observes one whole plane period (fetch of column 0 through last display cycle).
    task automatic observe_plane(input int r, input int p, input bit expect_done, input int drop_at);
        int         period;
        int         n_rise, n_latch, n_oe, n_rd;
        logic       prev_bclk, prev_oe;
        logic [2:0] prev_rgb;
        logic [2:0] exp_t, exp_b;
        period    = 4 * 3 + 2 + (2 << p);
        n_rise    = 0; n_latch = 0; n_oe = 0; n_rd = 0;
        prev_bclk = 1'b0; prev_oe = 1'b0; prev_rgb = 3'b0;
        for (int i = 0; i < period; i++) begin
            @(negedge clk);
            if (i == drop_at) enable_s = 1'b0;
            if (i == 0) begin
                checks++;
                if (rd_en_s !== 1'b1) begin
                    failures++;
                    $display("FAIL plane_start r%0d p%0d: rd_en=%b required 1", r, p, rd_en_s);
                end
            end
            if (rd_en_s === 1'b1) begin
                checks++;
                if (row_s !== 1'(r) || col_s !== 2'(n_rd)) begin
                    failures++;
                    $display("FAIL read_addr r%0d p%0d: row=%0d col=%0d required row=%0d col=%0d",
                             r, p, row_s, col_s, r, n_rd);
                end
                n_rd++;
            end
            if (bclk_s === 1'b1 && prev_bclk === 1'b0) begin
                if (n_rise < 4) begin
                    exp_t = plane_bits(fb_top[r][n_rise], p);
                    exp_b = plane_bits(fb_bot[r][n_rise], p);
                    checks++;
                    if (rgb_top_s !== exp_t || rgb_bot_s !== exp_b) begin
                        failures++;
                        $display("FAIL rgb r%0d p%0d c%0d: top=%b bot=%b required top=%b bot=%b",
                                 r, p, n_rise, rgb_top_s, rgb_bot_s, exp_t, exp_b);
                    end
                end
                last_rgb_top = rgb_top_s;
                n_rise++;
            end
            if (latch_s === 1'b1) begin
                n_latch++;
                checks++;
                if (addr_s !== 1'(r)) begin
                    failures++;
                    $display("FAIL latch_addr r%0d p%0d: addr=%0d required %0d", r, p, addr_s, r);
                end
                checks++;
                if (prev_rgb !== 3'b0 || prev_bclk !== 1'b0 || prev_oe !== 1'b0) begin
                    failures++;
                    $display("FAIL blank r%0d p%0d: rgb=%b bclk=%b oe=%b required all 0",
                             r, p, prev_rgb, prev_bclk, prev_oe);
                end
                last_addr = addr_s;
            end else begin
                checks++;
                if (addr_s !== last_addr) begin
                    failures++;
                    $display("FAIL addr_stable r%0d p%0d cycle %0d: addr=%0d required %0d",
                             r, p, i, addr_s, last_addr);
                end
            end
            if (oe_s === 1'b1) n_oe++;
            checks++;
            if (oe_s === 1'b1 && latch_s === 1'b1) begin
                failures++;
                $display("FAIL oe_latch_overlap r%0d p%0d: oe=1 latch=1 required not both", r, p);
            end
            if (i == period - 1) begin
                checks++;
                if (done_s !== expect_done) begin
                    failures++;
                    $display("FAIL frame_done r%0d p%0d: done=%b required %b", r, p, done_s, expect_done);
                end
                if (done_s === 1'b1) done_cyc = cyc;
                checks++;
                if (oe_s !== 1'b1) begin
                    failures++;
                    $display("FAIL display_end r%0d p%0d: oe=%b required 1", r, p, oe_s);
                end
            end else begin
                checks++;
                if (done_s !== 1'b0) begin
                    failures++;
                    $display("FAIL frame_done_early r%0d p%0d cycle %0d: done=%b required 0", r, p, i, done_s);
                end
            end
            prev_bclk = bclk_s; prev_oe = oe_s; prev_rgb = rgb_top_s | rgb_bot_s;
        end
        checks++;
        if (n_rise != 4) begin
            failures++;
            $display("FAIL bit_clk_rises r%0d p%0d: %0d required 4", r, p, n_rise);
        end
        checks++;
        if (n_latch != 1) begin
            failures++;
            $display("FAIL latch_count r%0d p%0d: %0d required 1", r, p, n_latch);
        end
        checks++;
        if (n_oe != (2 << p)) begin
            failures++;
            $display("FAIL oe_width r%0d p%0d: %0d required %0d", r, p, n_oe, 2 << p);
        end
        checks++;
        if (n_rd != 4) begin
            failures++;
            $display("FAIL read_count r%0d p%0d: %0d required 4", r, p, n_rd);
        end
    endtask

    task automatic observe_frame();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 2; p++)
                observe_plane(r, p, (r == 1 && p == 1), -1);
    endtask

    task automatic test_reset();
        n_reset_s = 1'b0; enable_s = 1'b0;
        n_reset_d = 1'b0; enable_d = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rd_en_s, bclk_s, latch_s, oe_s, busy_s, done_s} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: rd/bclk/le/oe/busy/done=%b required 000000",
                     {rd_en_s, bclk_s, latch_s, oe_s, busy_s, done_s});
        end
        checks++;
        if ({rgb_top_s, rgb_bot_s, addr_s, row_s, col_s} !== 11'b0) begin
            failures++;
            $display("FAIL reset_data: rgb=%b/%b addr=%0d row=%0d col=%0d required all 0",
                     rgb_top_s, rgb_bot_s, addr_s, row_s, col_s);
        end
        checks++;
        if ({rd_en_d, bclk_d, latch_d, oe_d, busy_d, done_d, rgb_top_d, rgb_bot_d, addr_d} !== 16'b0) begin
            failures++;
            $display("FAIL reset_default_dut: outputs=%h required 0",
                     {rd_en_d, bclk_d, latch_d, oe_d, busy_d, done_d, rgb_top_d, rgb_bot_d, addr_d});
        end
        n_reset_s = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_s !== 1'b0 || rd_en_s !== 1'b0) begin
            failures++;
            $display("FAIL idle_without_enable: busy=%b rd_en=%b required 0 0", busy_s, rd_en_s);
        end
        $display("test_reset done");
    endtask

    task automatic test_random_frames();
        int first_done;
        randomize_fb();
        enable_s = 1'b1;
        observe_frame();
        first_done = done_cyc;
        observe_frame();
        checks++;
        if (done_cyc - first_done != 68) begin
            failures++;
            $display("FAIL frame_period: %0d cycles required 68", done_cyc - first_done);
        end
        $display("test_random_frames done: frame period %0d", done_cyc - first_done);
    endtask

    task automatic test_fixed_pattern();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) begin
                fb_top[r][c] = 6'b11_01_10;
                fb_bot[r][c] = 6'b0;
            end
        observe_plane(0, 0, 1'b0, -1);
        checks++;
        if (last_rgb_top !== 3'b110) begin
            failures++;
            $display("FAIL pattern_plane0: rgb_top=%b required 110", last_rgb_top);
        end
        observe_plane(0, 1, 1'b0, -1);
        checks++;
        if (last_rgb_top !== 3'b101) begin
            failures++;
            $display("FAIL pattern_plane1: rgb_top=%b required 101", last_rgb_top);
        end
        observe_plane(1, 0, 1'b0, -1);
        observe_plane(1, 1, 1'b1, -1);
        $display("test_fixed_pattern done");
    endtask

    task automatic test_enable_drop();
        randomize_fb();
        observe_plane(0, 0, 1'b0, -1);
        observe_plane(0, 1, 1'b0, -1);
        observe_plane(1, 0, 1'b0, 3);
        observe_plane(1, 1, 1'b1, -1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({busy_s, rd_en_s, bclk_s, latch_s, oe_s, done_s, rgb_top_s, rgb_bot_s, addr_s} !== 13'b0) begin
                failures++;
                $display("FAIL idle_after_drop cycle %0d: busy/rd/bclk/le/oe/done/rgb/addr=%b required 0",
                         i, {busy_s, rd_en_s, bclk_s, latch_s, oe_s, done_s, rgb_top_s, rgb_bot_s, addr_s});
            end
        end
        last_addr = 1'b0;
        $display("test_enable_drop done");
    endtask

    task automatic test_reset_mid_display();
        bit found;
        found = 1'b0;
        randomize_fb();
        enable_s = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (oe_s === 1'b1 && addr_s === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reach_display_row1: oe/addr=1 not seen in 200 cycles required seen");
        end
        n_reset_s = 1'b0;
        @(negedge clk);
        checks++;
        if ({oe_s, busy_s, latch_s, rd_en_s, bclk_s, rgb_top_s, rgb_bot_s, addr_s} !== 12'b0) begin
            failures++;
            $display("FAIL reset_mid_display: oe/busy/le/rd/bclk/rgb/addr=%b required 0",
                     {oe_s, busy_s, latch_s, rd_en_s, bclk_s, rgb_top_s, rgb_bot_s, addr_s});
        end
        n_reset_s = 1'b1;
        last_addr = 1'b0;
        observe_frame();
        n_reset_s = 1'b0; enable_s = 1'b0;
        @(negedge clk);
        $display("test_reset_mid_display done");
    endtask

    task automatic test_default_params();
        int   rises[$];
        int   highs[$];
        int   oes[$];
        int   hi_len, oe_len, n_done;
        logic prev_bclk, prev_oe;
        hi_len = 0; oe_len = 0; n_done = 0;
        prev_bclk = 1'b0; prev_oe = 1'b0;
        n_reset_d = 1'b1; enable_d = 1'b1;
        for (int i = 0; i < 30000 && oes.size() < 4; i++) begin
            @(negedge clk);
            if (bclk_d === 1'b1) begin
                if (prev_bclk === 1'b0) rises.push_back(i);
                hi_len++;
            end else if (prev_bclk === 1'b1) begin
                highs.push_back(hi_len);
                hi_len = 0;
            end
            if (oe_d === 1'b1) oe_len++;
            else if (prev_oe === 1'b1) begin
                oes.push_back(oe_len);
                oe_len = 0;
            end
            if (done_d === 1'b1) n_done++;
            prev_bclk = bclk_d; prev_oe = oe_d;
        end
        checks++;
        if (oes.size() != 4) begin
            failures++;
            $display("FAIL default_timeout: %0d on-pulses required 4", oes.size());
        end
        if (oes.size() == 4 && highs.size() >= 3 && rises.size() >= 3) begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (highs[k] != 50) begin
                    failures++;
                    $display("FAIL bit_clk_high %0d: %0d cycles required 50", k, highs[k]);
                end
            end
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (rises[k] - rises[k-1] != 101) begin
                    failures++;
                    $display("FAIL bit_clk_spacing %0d: %0d cycles required 101", k, rises[k] - rises[k-1]);
                end
            end
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (oes[k] != (64 << k)) begin
                    failures++;
                    $display("FAIL default_oe plane %0d: %0d cycles required %0d", k, oes[k], 64 << k);
                end
            end
            checks++;
            if (rises.size() != 256) begin
                failures++;
                $display("FAIL default_rises: %0d required 256", rises.size());
            end
            checks++;
            if (n_done != 0) begin
                failures++;
                $display("FAIL default_done_in_row0: %0d pulses required 0", n_done);
            end
        end
        $display("test_default_params done: plane 3 on-time %0d", (oes.size() == 4) ? oes[3] : -1);
        n_reset_d = 1'b0; enable_d = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_random_frames();
        test_fixed_pattern();
        test_enable_drop();
        test_reset_mid_display();
        test_default_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
